// File: rtl/mem_arbiter_pkg.sv
// Shared types for the icache/dcache memory-port arbiter: FSM state encoding and owner IDs.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ADDR  = 2'd1,
        ARB_WDATA = 2'd2,
        ARB_RRESP = 2'd3
    } arb_state_e;

    localparam logic ARB_OWN_IC = 1'b0;
    localparam logic ARB_OWN_DC = 1'b1;

endpackage

// File: rtl/mem_arbiter_beat_counter.sv
// Beat counter shared by the write-data and read-response phases; last_o flags the final beat.
module mem_arbiter_beat_counter #(
    parameter int BURST_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic last_o
);

    // A one-beat burst still needs a 1-bit counter that simply stays at zero.
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (en_i && last_o)) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory port between icache refills and dcache refills/writebacks.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise the dcache wins every tie.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 128,
    parameter int BURST_LEN = 4,
    parameter int TAG_W     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ic_req_valid,
    output logic                ic_req_ready,
    input  logic [ADDR_W-1:0]   ic_req_addr,
    output logic                ic_resp_valid,
    output logic [DATA_W-1:0]   ic_resp_data,
    input  logic                dc_req_valid,
    output logic                dc_req_ready,
    input  logic                dc_req_rw,
    input  logic [ADDR_W-1:0]   dc_req_addr,
    input  logic                dc_wdata_valid,
    output logic                dc_wdata_ready,
    input  logic [DATA_W-1:0]   dc_wdata,
    input  logic [DATA_W/8-1:0] dc_wmask,
    output logic                dc_resp_valid,
    output logic [DATA_W-1:0]   dc_resp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_rw,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [TAG_W-1:0]    mem_req_tag,
    output logic                mem_wdata_valid,
    input  logic                mem_wdata_ready,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,
    input  logic [TAG_W-1:0]    mem_resp_tag,
    output logic                busy
);

    arb_state_e         state_q;
    logic               owner_q;
    logic               rw_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [TAG_W-2:0]   tag_cnt_q;
    logic [TAG_W-1:0]   tag_q;
`ifdef ARB_RR_EN
    logic               last_grant_q;
`endif

    logic ic_win, dc_win, accept;
    logic in_addr, in_wdata, in_rresp;
    logic wbeat, rbeat, beat_last;

    assign in_addr  = (state_q == ARB_ADDR);
    assign in_wdata = (state_q == ARB_WDATA);
    assign in_rresp = (state_q == ARB_RRESP);

    always_comb begin
        ic_win = 1'b0;
        dc_win = 1'b0;
        if (state_q == ARB_IDLE && !reset) begin
            if (ic_req_valid && dc_req_valid) begin
`ifdef ARB_RR_EN
                dc_win = (last_grant_q == ARB_OWN_IC);
                ic_win = !dc_win;
`else
                dc_win = 1'b1;
`endif
            end else begin
                ic_win = ic_req_valid;
                dc_win = dc_req_valid;
            end
        end
    end

    assign accept       = ic_win || dc_win;
    assign ic_req_ready = ic_win;
    assign dc_req_ready = dc_win;

    assign mem_req_valid = in_addr;
    assign mem_req_rw    = in_addr && rw_q;
    assign mem_req_addr  = in_addr ? addr_q : '0;
    assign mem_req_tag   = in_addr ? {owner_q, tag_cnt_q} : '0;

    assign mem_wdata_valid = in_wdata && dc_wdata_valid;
    assign dc_wdata_ready  = in_wdata && mem_wdata_ready;
    assign mem_wdata       = in_wdata ? dc_wdata : '0;
    assign mem_wmask       = in_wdata ? dc_wmask : '0;
    assign wbeat           = mem_wdata_valid && mem_wdata_ready;

    // Only beats carrying this transaction's tag are forwarded; stale or foreign beats are dropped.
    assign rbeat         = in_rresp && mem_resp_valid && (mem_resp_tag == tag_q);
    assign ic_resp_valid = rbeat && (owner_q == ARB_OWN_IC);
    assign dc_resp_valid = rbeat && (owner_q == ARB_OWN_DC);
    assign ic_resp_data  = ic_resp_valid ? mem_resp_data : '0;
    assign dc_resp_data  = dc_resp_valid ? mem_resp_data : '0;

    assign busy = (state_q != ARB_IDLE);

    mem_arbiter_beat_counter #(
        .BURST_LEN (BURST_LEN)
    ) u_beat_counter (
        .clk    (clk),
        .reset  (reset),
        .en_i   (wbeat || rbeat),
        .clr_i  (state_q == ARB_IDLE),
        .last_o (beat_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= ARB_OWN_IC;
            rw_q         <= 1'b0;
            tag_cnt_q    <= '0;
            tag_q        <= '0;
`ifdef ARB_RR_EN
            last_grant_q <= ARB_OWN_IC;
`endif
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (accept) begin
                        owner_q      <= dc_win;
                        rw_q         <= dc_win && dc_req_rw;
                        state_q      <= ARB_ADDR;
`ifdef ARB_RR_EN
                        last_grant_q <= dc_win;
`endif
                    end
                end
                ARB_ADDR: begin
                    if (mem_req_ready) begin
                        tag_q     <= {owner_q, tag_cnt_q};
                        tag_cnt_q <= tag_cnt_q + 1'b1;
                        state_q   <= rw_q ? ARB_WDATA : ARB_RRESP;
                    end
                end
                ARB_WDATA: begin
                    if (wbeat && beat_last) state_q <= ARB_IDLE;
                end
                ARB_RRESP: begin
                    if (rbeat && beat_last) state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // Line address is pure datapath; it is only visible on the port while in ADDR.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= dc_win ? dc_req_addr : ic_req_addr;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of line transactions plus tie, abort and stall sequences.
module tb_mem_arbiter;

    localparam int ADDR_W    = 28;
    localparam int DATA_W    = 128;
    localparam int BURST_LEN = 4;
    localparam int TAG_W     = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                ic_req_valid, ic_req_ready;
    logic [ADDR_W-1:0]   ic_req_addr;
    logic                ic_resp_valid;
    logic [DATA_W-1:0]   ic_resp_data;
    logic                dc_req_valid, dc_req_ready, dc_req_rw;
    logic [ADDR_W-1:0]   dc_req_addr;
    logic                dc_wdata_valid, dc_wdata_ready;
    logic [DATA_W-1:0]   dc_wdata;
    logic [DATA_W/8-1:0] dc_wmask;
    logic                dc_resp_valid;
    logic [DATA_W-1:0]   dc_resp_data;
    logic                mem_req_valid, mem_req_ready, mem_req_rw;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [TAG_W-1:0]    mem_req_tag;
    logic                mem_wdata_valid, mem_wdata_ready;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wmask;
    logic                mem_resp_valid;
    logic [DATA_W-1:0]   mem_resp_data;
    logic [TAG_W-1:0]    mem_resp_tag;
    logic                busy;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
        .dc_req_addr(dc_req_addr), .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready),
        .dc_wdata(dc_wdata), .dc_wmask(dc_wmask),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag),
        .busy(busy)
    );

    typedef struct {
        bit                dc;
        logic [DATA_W-1:0] data;
    } rexp_t;

    typedef struct {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] mask;
    } wexp_t;

    typedef struct {
        bit                dc;
        bit                rw;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       seed;
        bit                gaps;
        bit                bad_tag;
        int                stall;
        bit                hold;
    } txn_t;

    rexp_t rq[$];
    wexp_t wq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int rbeats  = 0;
    int wbeats  = 0;

    logic [TAG_W-2:0] tb_tag_cnt = '0;
    logic [TAG_W-1:0] prev_tag   = '0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every forwarded read beat and every memory write handshake is popped and compared.
    always @(negedge clk) begin
        if (ic_resp_valid || dc_resp_valid) begin
            rbeats++;
            chk("resp_one_port", ic_resp_valid && dc_resp_valid, 1'b0);
            chk("resp_expected", rq.size() != 0, 1'b1);
            if (rq.size() != 0) begin
                rexp_t e;
                e = rq.pop_front();
                chk("resp_owner", dc_resp_valid, e.dc);
                chk("resp_data", dc_resp_valid ? dc_resp_data : ic_resp_data, e.data);
            end
        end
        if (mem_wdata_valid && mem_wdata_ready) begin
            wbeats++;
            chk("wbeat_expected", wq.size() != 0, 1'b1);
            if (wq.size() != 0) begin
                wexp_t w;
                w = wq.pop_front();
                chk("wbeat_data", mem_wdata, w.data);
                chk("wbeat_mask", mem_wmask, w.mask);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(input bit icv, input bit dcv, input bit rw,
                             input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da, input bit exp_dc);
        ic_req_valid = icv;
        ic_req_addr  = ia;
        dc_req_valid = dcv;
        dc_req_rw    = rw;
        dc_req_addr  = da;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("ic_req_ready", ic_req_ready, !exp_dc);
        chk("dc_req_ready", dc_req_ready, exp_dc);
        next_cycle();
        if (exp_dc) dc_req_valid = 1'b0;
        else        ic_req_valid = 1'b0;
    endtask

    task automatic addr_phase(input bit dc, input bit rw, input logic [ADDR_W-1:0] addr,
                              input int stall, output logic [TAG_W-1:0] tag);
        tag = {dc, tb_tag_cnt};
        for (int i = 0; i <= stall; i++) begin
            mem_req_ready  = (i == stall);
            mem_resp_valid = (i < stall);
            mem_resp_tag   = prev_tag;
            mem_resp_data  = {4{32'hDEAD0000 + 32'(i)}};
            @(negedge clk);
            chk("mem_req_valid", mem_req_valid, 1'b1);
            chk("mem_req_addr", mem_req_addr, addr);
            chk("mem_req_tag", mem_req_tag, tag);
            chk("mem_req_rw", mem_req_rw, rw);
            chk("addr_no_ready", ic_req_ready || dc_req_ready, 1'b0);
            chk("addr_busy", busy, 1'b1);
            next_cycle();
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        tb_tag_cnt     = tb_tag_cnt + 1'b1;
        prev_tag       = tag;
    endtask

    task automatic wdata_phase(input logic [31:0] seed, input bit gaps, input logic [TAG_W-1:0] tag);
        int start;
        start = wbeats;
        for (int b = 0; b < BURST_LEN; b++) begin
            logic [DATA_W-1:0]   wd;
            logic [DATA_W/8-1:0] wm;
            wd = {4{seed + 32'(b)}};
            wm = 16'hF00F ^ (16'h1111 * 16'(b));
            wq.push_back('{data: wd, mask: wm});
            if (gaps && b == 1) begin
                dc_wdata_valid  = 1'b0;
                mem_wdata_ready = 1'b1;
                mem_resp_valid  = 1'b1;
                mem_resp_tag    = tag;
                mem_resp_data   = '1;
                @(negedge clk);
                chk("wgap_valid", mem_wdata_valid, 1'b0);
                next_cycle();
                mem_resp_valid = 1'b0;
            end
            if (gaps && b == 2) begin
                dc_wdata_valid  = 1'b1;
                dc_wdata        = wd;
                dc_wmask        = wm;
                mem_wdata_ready = 1'b0;
                @(negedge clk);
                chk("wstall_valid", mem_wdata_valid, 1'b1);
                chk("wstall_ready", dc_wdata_ready, 1'b0);
                next_cycle();
            end
            dc_wdata_valid  = 1'b1;
            dc_wdata        = wd;
            dc_wmask        = wm;
            mem_wdata_ready = 1'b1;
            @(negedge clk);
            chk("wbeat_busy", busy, 1'b1);
            chk("wbeat_ready", dc_wdata_ready, 1'b1);
            next_cycle();
        end
        dc_wdata_valid  = 1'b0;
        mem_wdata_ready = 1'b0;
        chk("wbeat_count", wbeats - start, BURST_LEN);
    endtask

    task automatic rresp_phase(input bit dc, input logic [31:0] seed, input bit bad,
                               input logic [TAG_W-1:0] tag);
        int start;
        start = rbeats;
        for (int b = 0; b < BURST_LEN; b++) begin
            logic [DATA_W-1:0] d;
            if (bad && b == 2) begin
                for (int k = 0; k < 2; k++) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_tag   = tag ^ ((k == 0) ? 4'h1 : 4'h8);
                    mem_resp_data  = {4{32'hBAD0BAD0}};
                    @(negedge clk);
                    chk("badtag_dropped", ic_resp_valid || dc_resp_valid, 1'b0);
                    chk("badtag_busy", busy, 1'b1);
                    next_cycle();
                end
            end
            d = {seed + 32'(b), ~(seed + 32'(b)), seed ^ 32'hA5A5A5A5, 32'(b)};
            rq.push_back('{dc: dc, data: d});
            mem_resp_valid = 1'b1;
            mem_resp_tag   = tag;
            mem_resp_data  = d;
            @(negedge clk);
            chk("rbeat_busy", busy, 1'b1);
            next_cycle();
        end
        mem_resp_valid = 1'b0;
        chk("rbeat_count", rbeats - start, BURST_LEN);
    endtask

    txn_t tbl[6];
    bit   tie_exp[3];

    initial begin
        logic [TAG_W-1:0] tag;

        tbl[0] = '{dc: 0, rw: 0, addr: 28'h0000010, seed: 32'h1000, gaps: 0, bad_tag: 0, stall: 0,  hold: 0};
        tbl[1] = '{dc: 1, rw: 1, addr: 28'h0000020, seed: 32'h2000, gaps: 1, bad_tag: 0, stall: 0,  hold: 0};
        tbl[2] = '{dc: 1, rw: 0, addr: 28'h0000030, seed: 32'h3000, gaps: 0, bad_tag: 1, stall: 0,  hold: 0};
        tbl[3] = '{dc: 0, rw: 0, addr: 28'hFFFFFFF, seed: 32'h4000, gaps: 0, bad_tag: 1, stall: 2,  hold: 0};
        tbl[4] = '{dc: 1, rw: 1, addr: 28'h0000000, seed: 32'h5000, gaps: 0, bad_tag: 0, stall: 3,  hold: 1};
        tbl[5] = '{dc: 0, rw: 0, addr: 28'h0000040, seed: 32'h6000, gaps: 0, bad_tag: 0, stall: 10, hold: 1};
`ifdef ARB_RR_EN
        tie_exp = '{1'b1, 1'b0, 1'b1};
`else
        tie_exp = '{1'b1, 1'b1, 1'b1};
`endif

        reset = 1'b1;
        ic_req_valid = 1'b1; ic_req_addr = 28'h1234567;
        dc_req_valid = 1'b1; dc_req_rw = 1'b1; dc_req_addr = 28'h7654321;
        dc_wdata_valid = 1'b1; dc_wdata = '1; dc_wmask = '1;
        mem_req_ready = 1'b1; mem_wdata_ready = 1'b1;
        mem_resp_valid = 1'b1; mem_resp_data = '1; mem_resp_tag = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", {ic_req_ready, dc_req_ready}, 2'b00);
        chk("rst_mem_req", {mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag}, '0);
        chk("rst_wdata", {mem_wdata_valid, dc_wdata_ready, mem_wdata, mem_wmask}, '0);
        chk("rst_resp", {ic_resp_valid, dc_resp_valid, ic_resp_data, dc_resp_data}, '0);
        next_cycle();
        reset = 1'b0;
        ic_req_valid = 1'b0; dc_req_valid = 1'b0; dc_req_rw = 1'b0;
        dc_wdata_valid = 1'b0; mem_req_ready = 1'b0; mem_wdata_ready = 1'b0; mem_resp_valid = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_accept(!tbl[i].dc, tbl[i].dc, tbl[i].rw, tbl[i].addr, tbl[i].addr, tbl[i].dc);
            if (tbl[i].hold) begin
                if (tbl[i].dc) dc_req_valid = 1'b1;
                else           ic_req_valid = 1'b1;
            end
            addr_phase(tbl[i].dc, tbl[i].rw, tbl[i].addr, tbl[i].stall, tag);
            ic_req_valid = 1'b0;
            dc_req_valid = 1'b0;
            if (tbl[i].rw) wdata_phase(tbl[i].seed, tbl[i].gaps, tag);
            else           rresp_phase(tbl[i].dc, tbl[i].seed, tbl[i].bad_tag, tag);
        end

        // Simultaneous requests three times in a row; the loser keeps its request up.
        for (int r = 0; r < 3; r++) begin
            logic [ADDR_W-1:0] ia, da;
            ia = 28'h0000100 + 28'(r);
            da = 28'h0000200 + 28'(r);
            do_accept(1'b1, 1'b1, 1'b0, ia, da, tie_exp[r]);
            addr_phase(tie_exp[r], 1'b0, tie_exp[r] ? da : ia, 0, tag);
            rresp_phase(tie_exp[r], 32'h7000 + 32'(r << 8), 1'b0, tag);
        end
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;

        // Abort a writeback with reset while its third beat is stalled.
        do_accept(1'b0, 1'b1, 1'b1, '0, 28'h0000050, 1'b1);
        addr_phase(1'b1, 1'b1, 28'h0000050, 0, tag);
        for (int b = 0; b < 2; b++) begin
            wq.push_back('{data: {4{32'h8000 + 32'(b)}}, mask: 16'h00FF});
            dc_wdata_valid = 1'b1; dc_wdata = {4{32'h8000 + 32'(b)}}; dc_wmask = 16'h00FF;
            mem_wdata_ready = 1'b1;
            next_cycle();
        end
        dc_wdata_valid = 1'b1; dc_wdata = {4{32'h8002}}; mem_wdata_ready = 1'b0;
        dc_req_valid = 1'b1; dc_req_rw = 1'b0; dc_req_addr = 28'h0000060;
        #1;
        chk("pre_abort_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_wdata", {mem_wdata_valid, dc_wdata_ready, mem_wdata, mem_wmask}, '0);
        chk("abort_req", {mem_req_valid, dc_req_ready, ic_req_ready}, '0);
        wq.delete();
        tb_tag_cnt = '0;
        prev_tag   = '0;
        next_cycle();
        reset = 1'b0;
        dc_wdata_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_tag = tag; mem_resp_data = {4{32'h1A7E1A7E}};
        do_accept(1'b0, 1'b1, 1'b0, '0, 28'h0000060, 1'b1);
        mem_resp_valid = 1'b0;
        addr_phase(1'b1, 1'b0, 28'h0000060, 0, tag);
        rresp_phase(1'b1, 32'h9000, 1'b0, tag);
        @(negedge clk);
        chk("final_busy", busy, 1'b0);
        chk("final_rq_empty", rq.size(), 0);
        chk("final_wq_empty", wq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
